// File: rtl/packet_fifo_pkg.sv
// Shared definitions for the packet FIFO write arbiter.
//   state_t         : write sequencer states (ARB, INFO, DATA)
//   ADDR_*          : FIFO write-slave addresses (0 = data word, 1 = other-info)
//   INFO_*          : bit positions inside the other-info word
//   byte_reverse32  : byte swap that undoes the FIFO's symbol ordering
//   info_word       : packs sop/eop/empty into the other-info write
package packet_fifo_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    INFO = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_INFO = 1'b1;

  localparam int INFO_SOP      = 0;
  localparam int INFO_EOP      = 1;
  localparam int INFO_EMPTY_LO = 2;
  localparam int INFO_EMPTY_HI = 3;

  // The FIFO emits byte 0 of the written word last, so swapping here makes the
  // source side present exactly the word the requester supplied.
  function automatic logic [31:0] byte_reverse32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [31:0] info_word(input logic       sop,
                                            input logic       eop,
                                            input logic [1:0] empty);
    logic [31:0] w;
    w                             = '0;
    w[INFO_SOP]                   = sop;
    w[INFO_EOP]                   = eop;
    w[INFO_EMPTY_HI:INFO_EMPTY_LO] = empty;
    return w;
  endfunction

endpackage

// File: rtl/packet_fifo_credit_counter.sv
// Free-word credit counter for a FIFO that exposes no full/waitrequest.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (count -> DEPTH)
//   i_dec        : one data word written into the FIFO this cycle
//   i_inc        : one word delivered by the FIFO source this cycle
//   o_credits    : current number of free FIFO words
//   o_err        : sticky, a return arrived while already at DEPTH
module packet_fifo_credit_counter #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_dec,
  input  logic          i_inc,
  output logic [CW-1:0] o_credits,
  output logic          o_err
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] r_credits;
  logic          r_err;

  // NOTE: sequential state is written with non-blocking (<=) so every flop
  // samples pre-edge values no matter how the statements are ordered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credits <= FULL;
      r_err     <= 1'b0;
    end else begin
      if (i_inc && !i_dec) begin
        // A return while already full is spurious: saturate and flag it.
        if (r_credits != FULL) r_credits <= r_credits + 1'b1;
      end else if (i_dec && !i_inc) begin
        if (r_credits != '0) r_credits <= r_credits - 1'b1;
      end
      if (i_inc && (r_credits == FULL)) r_err <= 1'b1;
    end
  end

  assign o_credits = r_credits;
  assign o_err     = r_err;

endmodule

// File: rtl/packet_fifo_write_arbiter.sv
// Round-robin, packet-atomic arbiter from two Avalon-ST requesters into the
// two-address Avalon-MM write slave of a packet FIFO.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   sN_valid/ready/data/startofpacket/endofpacket/empty : requester N (0, 1)
//   avm_address/write/writedata : FIFO write slave (1 = other-info, 0 = data)
//   credit_return         : one pulse per word leaving the FIFO
//   grant                 : one-hot packet owner, 0 when unlocked
//   credits               : current free-word count
//   err_nosop, err_credit : sticky protocol error flags
module packet_fifo_write_arbiter
  import packet_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [31:0]   s0_data,
  input  logic          s0_startofpacket,
  input  logic          s0_endofpacket,
  input  logic [1:0]    s0_empty,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [31:0]   s1_data,
  input  logic          s1_startofpacket,
  input  logic          s1_endofpacket,
  input  logic [1:0]    s1_empty,
  output logic          avm_address,
  output logic          avm_write,
  output logic [31:0]   avm_writedata,
  input  logic          credit_return,
  output logic [1:0]    grant,
  output logic [CW-1:0] credits,
  output logic          err_nosop,
  output logic          err_credit
);

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_grant;
  logic          r_rr_last;      // requester that took the most recent lock
  logic [31:0]   r_hold_data;
  logic          r_hold_eop;
  logic          r_avm_address;
  logic          r_avm_write;
  logic [31:0]   r_avm_writedata;
  logic          r_err_nosop;

  logic          w_sel;          // index of the chosen candidate
  logic          w_sel_vld;
  logic          w_accept;
  logic          w_locked;
  logic          w_discard;
  logic [31:0]   w_b_data;
  logic          w_b_sop;
  logic          w_b_eop;
  logic [1:0]    w_b_empty;
  logic [CW-1:0] w_credits;

  assign w_locked = |r_grant;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_sel     = 1'b0;
    w_sel_vld = 1'b0;
    if (r_grant[0]) begin
      w_sel_vld = s0_valid;
    end else if (r_grant[1]) begin
      w_sel     = 1'b1;
      w_sel_vld = s1_valid;
    end else if (s0_valid && s1_valid) begin
      w_sel     = ~r_rr_last;
      w_sel_vld = 1'b1;
    end else if (s0_valid) begin
      w_sel_vld = 1'b1;
    end else if (s1_valid) begin
      w_sel     = 1'b1;
      w_sel_vld = 1'b1;
    end
  end

  // Ready only in ARB and only with a free FIFO word, so a captured beat can
  // always finish its writes without overflowing the FIFO.
  assign w_accept = !reset && (r_state == ARB) && w_sel_vld && (w_credits != '0);
  assign s0_ready = w_accept && !w_sel;
  assign s1_ready = w_accept &&  w_sel;

  assign w_b_data  = w_sel ? s1_data          : s0_data;
  assign w_b_sop   = w_sel ? s1_startofpacket : s0_startofpacket;
  assign w_b_eop   = w_sel ? s1_endofpacket   : s0_endofpacket;
  assign w_b_empty = w_sel ? s1_empty         : s0_empty;

  // A packet can only be opened by sop; stray beats are drained and flagged.
  assign w_discard = w_accept && !w_locked && !w_b_sop;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ARB:     if (w_accept && !w_discard) w_state_next = (w_b_sop || w_b_eop) ? INFO : DATA;
      INFO:    w_state_next = DATA;
      DATA:    w_state_next = ARB;
      default: w_state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ARB;
    else       r_state <= w_state_next;
  end

  // The Avalon-MM outputs are registered and loaded one edge ahead, so the
  // write appears in the same cycle as the state it belongs to. Address and
  // data simply keep their last value while no write is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant         <= 2'b00;
      r_rr_last       <= 1'b1;   // pretend s1 went last so s0 wins first
      r_hold_data     <= '0;
      r_hold_eop      <= 1'b0;
      r_avm_address   <= ADDR_DATA;
      r_avm_write     <= 1'b0;
      r_avm_writedata <= '0;
      r_err_nosop     <= 1'b0;
    end else begin
      r_avm_write <= 1'b0;
      unique case (r_state)
        ARB: begin
          if (w_discard) begin
            r_err_nosop <= 1'b1;
          end else if (w_accept) begin
            r_hold_data <= w_b_data;
            r_hold_eop  <= w_b_eop;
            if (!w_locked) begin
              r_grant   <= w_sel ? 2'b10 : 2'b01;
              r_rr_last <= w_sel;
            end
            r_avm_write <= 1'b1;
            if (w_b_sop || w_b_eop) begin
              // The info word is built straight from the beat, so sop and
              // empty never need to be held beyond this edge.
              r_avm_address   <= ADDR_INFO;
              r_avm_writedata <= info_word(w_b_sop, w_b_eop, w_b_empty);
            end else begin
              r_avm_address   <= ADDR_DATA;
              r_avm_writedata <= byte_reverse32(w_b_data);
            end
          end
        end
        INFO: begin
          r_avm_write     <= 1'b1;
          r_avm_address   <= ADDR_DATA;
          r_avm_writedata <= byte_reverse32(r_hold_data);
        end
        DATA: begin
          if (r_hold_eop) r_grant <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  packet_fifo_credit_counter #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_credit (
    .clk       (clk),
    .reset     (reset),
    .i_dec     (r_state == DATA),
    .i_inc     (credit_return),
    .o_credits (w_credits),
    .o_err     (err_credit)
  );

  assign avm_address   = r_avm_address;
  assign avm_write     = r_avm_write;
  assign avm_writedata = r_avm_writedata;
  assign grant         = r_grant;
  assign credits       = w_credits;
  assign err_nosop     = r_err_nosop;

endmodule
